// File: rtl/merge_grant_arbiter.sv
// Packet-level two-input grant arbiter for one router output merge.
// Holds the grant for PKT_FLITS transfers, then hands priority to the other input.
module merge_grant_arbiter #(
  parameter int PKT_FLITS = 4,
  parameter int CNT_W     = 8
) (
  input  logic       CLK,
  input  logic       _RESET,
  input  logic [1:0] req_i,
  input  logic       flit_xfer_i,
  output logic [1:0] grant_o,
  output logic [1:0] done_o,
  output logic       busy_o,
  output logic       err_o
);

  // state   | meaning
  // IDLE    | no grant, sampling req_i
  // GRANT   | grant_o one-hot on own, counting flits
  // RELEASE | one-cycle bubble so the finished requester can drop req_i
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_FLITS - 1);

  state_t           state;
  logic             prio;
  logic             own;
  logic [CNT_W-1:0] cnt;
  logic             pick;

  // A lone requester wins outright; a tie goes to the favoured input.
  assign pick = (req_i == 2'b11) ? prio : req_i[1];

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state   <= IDLE;
      prio    <= 1'b0;
      own     <= 1'b0;
      cnt     <= '0;
      grant_o <= 2'b00;
      done_o  <= 2'b00;
      busy_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      done_o <= 2'b00;
      case (state)
        IDLE: begin
          if (flit_xfer_i) err_o <= 1'b1;
          if (req_i != 2'b00) begin
            own     <= pick;
            grant_o <= {pick, ~pick};
            busy_o  <= 1'b1;
            cnt     <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!req_i[own]) err_o <= 1'b1;
          if (flit_xfer_i) begin
            if (cnt == LAST) begin
              done_o  <= {own, ~own};
              prio    <= ~own;
              grant_o <= 2'b00;
              busy_o  <= 1'b0;
              state   <= RELEASE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RELEASE: begin
          if (flit_xfer_i) err_o <= 1'b1;
          state <= IDLE;
        end
        default: begin
          grant_o <= 2'b00;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_merge_grant_arbiter.sv
// Directed bench for merge_grant_arbiter: a PKT_FLITS=4 instance and a PKT_FLITS=1 instance.
module tb_merge_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, req1;
  logic       flit, flit1;
  logic [1:0] grant, done, grant1, done1;
  logic       busy, err, busy1, err1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  merge_grant_arbiter #(.PKT_FLITS(4), .CNT_W(8)) dut (
    .CLK(clk), ._RESET(rst_n), .req_i(req), .flit_xfer_i(flit),
    .grant_o(grant), .done_o(done), .busy_o(busy), .err_o(err)
  );

  merge_grant_arbiter #(.PKT_FLITS(1), .CNT_W(8)) dut1 (
    .CLK(clk), ._RESET(rst_n), .req_i(req1), .flit_xfer_i(flit1),
    .grant_o(grant1), .done_o(done1), .busy_o(busy1), .err_o(err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 2'b00; flit = 1'b0; req1 = 2'b00; flit1 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant, done, busy, err} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got=%b want=000000", {grant, done, busy, err});
    end
    // full packet for input 0 so prio moves to 1
    req = 2'b11;
    tick();
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL reset_first_grant got=%b want=01", grant); end
    for (int i = 0; i < 4; i++) begin flit = 1'b1; tick(); end
    flit = 1'b0; req = 2'b10;
    checks++;
    if (done !== 2'b01) begin errors++; $display("FAIL reset_pkt0_done got=%b want=01", done); end
    tick();
    tick();
    checks++;
    if (grant !== 2'b10) begin errors++; $display("FAIL reset_second_grant got=%b want=10", grant); end
    flit = 1'b1; tick(); tick(); flit = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, done, busy, err} !== 6'b0) begin
      errors++; $display("FAIL reset_async_midpkt got=%b want=000000", {grant, done, busy, err});
    end
    tick();
    rst_n = 1'b1; req = 2'b11;
    tick();
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL reset_prio_cleared got=%b want=01", grant); end
  endtask

  task automatic test_single();
    do_reset();
    req = 2'b10;
    tick();
    checks++;
    if (grant !== 2'b10 || busy !== 1'b1) begin
      errors++; $display("FAIL single_grant got=%b busy=%b want=10 busy=1", grant, busy);
    end
    for (int i = 0; i < 4; i++) begin
      flit = 1'b1; tick(); flit = 1'b0;
      checks++;
      if (i < 3 && (grant !== 2'b10 || done !== 2'b00)) begin
        errors++; $display("FAIL single_hold_%0d got=%b/%b want=10/00", i, grant, done);
      end else if (i == 3 && (grant !== 2'b00 || done !== 2'b10 || busy !== 1'b0)) begin
        errors++; $display("FAIL single_last got=%b/%b/%b want=00/10/0", grant, done, busy);
      end
    end
    req = 2'b00;
    tick();
    checks++;
    if (grant !== 2'b00 || done !== 2'b00) begin
      errors++; $display("FAIL single_release got=%b/%b want=00/00", grant, done);
    end
    tick();
    checks++;
    if (grant !== 2'b00 || err !== 1'b0) begin
      errors++; $display("FAIL single_idle got=%b err=%b want=00 err=0", grant, err);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    req = 2'b11;
    for (int p = 0; p < 3; p++) begin
      exp = (p % 2 == 0) ? 2'b01 : 2'b10;
      if (p > 0) begin
        tick();
        checks++;
        if (grant !== 2'b00 || done !== 2'b00) begin
          errors++; $display("FAIL rr_gap_%0d got=%b/%b want=00/00", p, grant, done);
        end
      end
      tick();
      checks++;
      if (grant !== exp) begin errors++; $display("FAIL rr_owner_%0d got=%b want=%b", p, grant, exp); end
      for (int i = 0; i < 4; i++) begin
        flit = 1'b1; tick(); flit = 1'b0;
        checks++;
        if (i < 3 && grant !== exp) begin
          errors++; $display("FAIL rr_hold_%0d_%0d got=%b want=%b", p, i, grant, exp);
        end else if (i == 3 && (done !== exp || grant !== 2'b00)) begin
          errors++; $display("FAIL rr_done_%0d got=%b/%b want=%b/00", p, done, grant, exp);
        end
      end
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rr_err got=%b want=0", err); end
  endtask

  task automatic test_stall();
    int bad;
    do_reset();
    req = 2'b01;
    tick();
    flit = 1'b1; tick(); tick(); flit = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (grant !== 2'b01 || done !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold bad_cycles=%0d want=0", bad); end
    flit = 1'b1; tick(); flit = 1'b0;
    checks++;
    if (grant !== 2'b01 || done !== 2'b00) begin
      errors++; $display("FAIL stall_third got=%b/%b want=01/00", grant, done);
    end
    flit = 1'b1; tick(); flit = 1'b0;
    checks++;
    if (grant !== 2'b00 || done !== 2'b01 || err !== 1'b0) begin
      errors++; $display("FAIL stall_done got=%b/%b err=%b want=00/01 err=0", grant, done, err);
    end
  endtask

  task automatic test_errors();
    do_reset();
    flit = 1'b1; tick(); flit = 1'b0;
    checks++;
    if (err !== 1'b1 || grant !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL err_idle_xfer got=%b/%b/%b want=1/00/0", err, grant, busy);
    end
    do_reset();
    req = 2'b01;
    tick();
    flit = 1'b1; tick(); flit = 1'b0;
    req = 2'b00;
    tick();
    checks++;
    if (err !== 1'b1 || grant !== 2'b01) begin
      errors++; $display("FAIL err_req_drop got=%b/%b want=1/01", err, grant);
    end
    for (int i = 0; i < 3; i++) begin
      flit = 1'b1; tick(); flit = 1'b0;
      checks++;
      if (i < 2 && grant !== 2'b01) begin
        errors++; $display("FAIL err_drop_hold_%0d got=%b want=01", i, grant);
      end else if (i == 2 && done !== 2'b01) begin
        errors++; $display("FAIL err_drop_done got=%b want=01", done);
      end
    end
    // transfer on the grant-entry edge is an IDLE transfer: flagged, not counted
    do_reset();
    req = 2'b01; flit = 1'b1;
    tick();
    flit = 1'b0;
    checks++;
    if (err !== 1'b1 || grant !== 2'b01) begin
      errors++; $display("FAIL err_entry_xfer got=%b/%b want=1/01", err, grant);
    end
    for (int i = 0; i < 4; i++) begin
      flit = 1'b1; tick(); flit = 1'b0;
      checks++;
      if (i < 3 && done !== 2'b00) begin
        errors++; $display("FAIL err_entry_early_done_%0d got=%b want=00", i, done);
      end else if (i == 3 && done !== 2'b01) begin
        errors++; $display("FAIL err_entry_done got=%b want=01", done);
      end
    end
  endtask

  task automatic test_pkt1();
    logic [1:0] exp;
    do_reset();
    req1 = 2'b11;
    for (int p = 0; p < 4; p++) begin
      exp = (p % 2 == 0) ? 2'b01 : 2'b10;
      if (p > 0) begin
        tick();
        checks++;
        if (grant1 !== 2'b00) begin errors++; $display("FAIL p1_gap_%0d got=%b want=00", p, grant1); end
      end
      tick();
      checks++;
      if (grant1 !== exp) begin errors++; $display("FAIL p1_owner_%0d got=%b want=%b", p, grant1, exp); end
      flit1 = 1'b1; tick(); flit1 = 1'b0;
      checks++;
      if (done1 !== exp || grant1 !== 2'b00) begin
        errors++; $display("FAIL p1_done_%0d got=%b/%b want=%b/00", p, done1, grant1, exp);
      end
    end
    checks++;
    if (err1 !== 1'b0) begin errors++; $display("FAIL p1_err got=%b want=0", err1); end
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; flit = 1'b0; req1 = 2'b00; flit1 = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_errors();
    test_pkt1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/merge_grant_arbiter.md
# merge_grant_arbiter

Clocked packet-level arbiter that drives the select (Grant) input of one router output-port merge, sharing that output between its two candidate input streams. It is instantiated once per output port (P, C1, C2) beside the router. Its requests come from the per-input route-select splits. It locks the grant for a whole packet of `PKT_FLITS` flits, then rotates priority round-robin.

## Interface
- `PKT_FLITS`, default 4: flits per packet; legal range 1..255.
- `CNT_W`, default 8: flit counter width; must hold `PKT_FLITS-1`.
- `CLK`  in  1  sole clock; all state updates on rising edge.
- `_RESET`  in  1  asynchronous, active-low reset.
- `req_i`  in  2  level request per input (bit0 = merge In0, bit1 = merge In1); held high by a requester until it sees its `done_o` bit.
- `flit_xfer_i`  in  1  one-cycle pulse per flit the merge has passed to the output.
- `grant_o`  out  2  one-hot select to the merge S channel; 2'b00 = no grant.
- `done_o`  out  2  one-cycle pulse on the owner's bit when its packet's last flit transfers.
- `busy_o`  out  1  high while any grant is held.
- `err_o`  out  1  sticky protocol-error flag.

## Operation
- State machine with three states.
  - IDLE: no grant.
  - GRANT: `grant_o` is held one-hot, owner is `own`.
  - RELEASE: one-cycle bubble.
- Priority pointer `prio` (1 bit) names the favoured input. Reset value is 0.
- IDLE → GRANT when `req_i` ≠ 0.
  - Only one request bit high: that input becomes owner.
  - Both high: input `prio` becomes owner.
  - Flit counter `cnt` clears to 0.
- GRANT, on `flit_xfer_i`:
  - If `cnt` < `PKT_FLITS-1`: increment `cnt`.
  - If `cnt` = `PKT_FLITS-1`: pulse `done_o[own]`, set `prio` to the other input (`~own`), go to RELEASE.
- GRANT with no `flit_xfer_i`: hold state indefinitely. There is no timeout.
- RELEASE → IDLE unconditionally. `req_i` is not sampled in RELEASE; this gives the finishing requester a cycle to drop its request.
- `PKT_FLITS`=1: every transfer completes a packet.
- The owner's `req_i` dropping during GRANT does not release the grant. Completion is by flit count only. The condition sets `err_o`.
- `flit_xfer_i` in IDLE or RELEASE is ignored for counting and sets `err_o`.
- `err_o` is cleared only by reset.
- Outputs are registered. `grant_o` = onehot(`own`) in GRANT, 0 otherwise. `busy_o` = (state == GRANT).

## Timing
- Reset (`_RESET` low, asynchronous): state=IDLE, `prio`=0, `cnt`=0, `own`=0. Outputs: `grant_o`=00, `done_o`=00, `busy_o`=0, `err_o`=0.
- `_RESET` deassertion is synchronised externally. The first edge after release may already grant.
- Request to grant latency: `req_i` high before edge N gives `grant_o` valid after edge N (1 cycle).
- Last-flit pulse:
  - `flit_xfer_i` at edge M on the last flit gives `done_o` high and `grant_o`=00 for cycle M..M+1.
  - State is back in IDLE after M+1.
  - Earliest next grant is after M+2.
- Minimum gap between packets: 2 idle-grant cycles (RELEASE plus IDLE sampling).
- Back-to-back packets with both inputs requesting continuously alternate owners: 0,1,0,1… starting from `prio`.
- Reset mid-packet aborts immediately. Grant drops asynchronously, with no `done_o` pulse. The partial packet is the upstream owner's concern.
- `flit_xfer_i` coincident with the GRANT entry edge is counted as an IDLE transfer, so it sets `err_o`.

## Test plan
- Reset check: assert `_RESET` low mid-GRANT with `cnt`=2 → `grant_o`=00, `busy_o`=0, `err_o`=0 immediately. After release, `prio`=0: request both → `grant_o`=01.
- Single requester: `req_i`=10, PKT_FLITS=4, four `flit_xfer_i` pulses → `grant_o`=10 from cycle 1 to the 4th pulse; `done_o`=10 for one cycle; `grant_o`=00 two cycles later.
- Round-robin: `req_i`=11 held for 3 packets → owners 0,1,0; each grant lasts exactly 4 transfers; `done_o` pulses 01,10,01.
- Stalled transfer: grant input 0, pulse `flit_xfer_i` twice, wait 50 cycles → `grant_o` stays 01, `cnt`=2, no `done_o`. Two more pulses then complete the packet normally.
- Protocol errors: `flit_xfer_i` pulse in IDLE → `err_o`=1 next cycle, no grant change. Separately, owner drops `req_i` mid-packet → `err_o`=1 and the grant is held until 4 transfers complete.
- PKT_FLITS=1 build: `req_i`=11 continuously with `flit_xfer_i` every GRANT cycle → grants alternate 01,10 with the 2-cycle gap; `done_o` pulses alternate.
